// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data-memory controller.
//   funct3 width/sign codes, FSM state type, byte-lane offset type, and
//   a helper that flags funct3 codes with no RV32I meaning.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_W = 2;
  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) f3_illegal = (f3 >= 3'b011);
    else    f3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and lsu_dmem_ctrl (slave).
//   req_*  : valid/ready request (we, funct3, byte address, right-aligned store data)
//   rsp_*  : single-cycle completion pulse with extended load data and error flag
interface lsu_dmem_ctrl_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for lsu_dmem_ctrl.
//   req_funct3/req_off/req_wdata -> byte_sel, wdata_sh (lane-replicated), misalign
//   ld_funct3/ld_off/mem_rdata   -> ld_data (extracted and sign/zero-extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  lane_t       req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  byte_sel,
  output logic [31:0] wdata_sh,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  lane_t       ld_off,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] rd_sh;

  // funct3[1:0] carries the access size for both signed and unsigned codes.
  always_comb begin
    byte_sel = 4'b0000;
    wdata_sh = 32'h0;
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b00: begin
        byte_sel = 4'(4'b0001 << req_off);
        wdata_sh = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_sel = 4'(4'b0011 << req_off);
        wdata_sh = {2{req_wdata[15:0]}};
        misalign = req_off[0];
      end
      2'b10: begin
        byte_sel = 4'hF;
        wdata_sh = req_wdata;
        misalign = (req_off != 2'b00);
      end
      default: ;
    endcase
  end

  assign rd_sh = mem_rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
      F3_BU:   ld_data = {24'h0, rd_sh[7:0]};
      F3_H:    ld_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
      F3_HU:   ld_data = {16'h0, rd_sh[15:0]};
      F3_W:    ld_data = mem_rdata;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller between the MEM stage and word-addressed data memory.
//   clk, rst_n   : clock (memory acts on negedge), async active-low reset
//   bus (slave)  : request/response handshake, see lsu_dmem_ctrl_if
//   mem_*        : word index, lane-shifted store data, enables, byte lanes, read word
// One request in flight: IDLE -> ACCESS -> RESP, or IDLE -> RESP on a rejected request.
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_dmem_ctrl_if.slave    bus,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [3:0]        mem_byte_sel,
  input  logic [31:0]       mem_rdata
);

  state_t        state, state_nx;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    sel_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [3:0]    sel_in;
  logic [31:0]   wdata_in;
  logic          misalign;
  logic [31:0]   ld_data;
  logic          out_of_range;
  logic          req_bad;
  logic          accept;

  // Lane selection and store shifting are evaluated on the incoming request and
  // registered at accept; extraction uses the registered request during ACCESS.
  lsu_align u_align (
    .req_funct3 (bus.req_funct3),
    .req_off    (bus.req_addr[1:0]),
    .req_wdata  (bus.req_wdata),
    .byte_sel   (sel_in),
    .wdata_sh   (wdata_in),
    .misalign   (misalign),
    .ld_funct3  (f3_q),
    .ld_off     (addr_q[1:0]),
    .mem_rdata  (mem_rdata),
    .ld_data    (ld_data)
  );

  assign out_of_range = (bus.req_addr >> 2) >= AW'(DEPTH_WORDS);
  assign req_bad      = misalign | out_of_range | f3_illegal(bus.req_we, bus.req_funct3);
  assign accept       = bus.req_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    mem_wen       = 1'b0;
    mem_ren       = 1'b0;
    mem_byte_sel  = 4'b0000;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_nx = req_bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_wen      = we_q;
        mem_ren      = !we_q;
        mem_byte_sel = sel_q;
        state_nx     = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      sel_q   <= 4'b0000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= wdata_in;
        sel_q   <= sel_in;
        if (req_bad) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end
      end
      if (state == S_ACCESS) begin
        err_q   <= 1'b0;
        rdata_q <= we_q ? 32'h0 : ld_data;
      end
    end
  end

  assign mem_addr      = 32'(addr_q >> 2);
  assign mem_wdata     = wdata_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
